tomasulo_rs: RTL and testbench

Parametrised reservation station for the Tomasulo core. It sits between the issue stage (fed by `pc` / `regbank` lookup) and one functional unit. It captures issued operations with their operand values or producer tags, snoops the common data bus (CDB) to wake waiting operands, and dispatches the oldest ready operation through a registered valid/ready port. Depth, data width, tag width and opcode width are generic, so the ALU, multiplier and load stations are all instances of this one block.

---
 rtl/tomasulo_rs.sv | 204 ++++++++++++++++++++
 tb/tb_tomasulo_rs.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tomasulo_rs.sv
// rtl/tomasulo_rs.sv - Reservation station: tag capture, CDB wakeup, oldest-ready dispatch
module tomasulo_rs #(
    parameter int ENTRIES = 4,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 3,
    parameter int OP_W    = 2,
    parameter int RS_BASE = 1
) (
    input  logic                         clk1,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         iss_valid,
    output logic                         iss_ready,
    input  logic [OP_W-1:0]              iss_op,
    input  logic [DATA_W-1:0]            iss_vj,
    input  logic [DATA_W-1:0]            iss_vk,
    input  logic [TAG_W-1:0]             iss_qj,
    input  logic [TAG_W-1:0]             iss_qk,
    output logic [TAG_W-1:0]             iss_tag,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_data,
    output logic                         ex_valid,
    input  logic                         ex_ready,
    output logic [OP_W-1:0]              ex_op,
    output logic [DATA_W-1:0]            ex_vj,
    output logic [DATA_W-1:0]            ex_vk,
    output logic [TAG_W-1:0]             ex_tag,
    output logic [$clog2(ENTRIES+1)-1:0] occupancy
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int OCC_W = $clog2(ENTRIES+1);
    localparam logic [ENTRIES-1:0] ONE_HOT0 = {{(ENTRIES-1){1'b0}}, 1'b1};

    logic [ENTRIES-1:0] busy_q, busy_d;
    logic [OP_W-1:0]    op_q [ENTRIES];
    logic [OP_W-1:0]    op_d [ENTRIES];
    logic [DATA_W-1:0]  vj_q [ENTRIES];
    logic [DATA_W-1:0]  vj_d [ENTRIES];
    logic [DATA_W-1:0]  vk_q [ENTRIES];
    logic [DATA_W-1:0]  vk_d [ENTRIES];
    logic [TAG_W-1:0]   qj_q [ENTRIES];
    logic [TAG_W-1:0]   qj_d [ENTRIES];
    logic [TAG_W-1:0]   qk_q [ENTRIES];
    logic [TAG_W-1:0]   qk_d [ENTRIES];
    // older_q[i][j] set means entry j was allocated before entry i
    logic [ENTRIES-1:0] older_q [ENTRIES];
    logic [ENTRIES-1:0] older_d [ENTRIES];

    logic               ex_valid_q, ex_valid_d;
    logic [OP_W-1:0]    ex_op_q, ex_op_d;
    logic [DATA_W-1:0]  ex_vj_q, ex_vj_d;
    logic [DATA_W-1:0]  ex_vk_q, ex_vk_d;
    logic [TAG_W-1:0]   ex_tag_q, ex_tag_d;

    logic [ENTRIES-1:0] ready;
    logic [ENTRIES-1:0] freed;
    logic               sel_any, alloc_any;
    logic [IDX_W-1:0]   sel_idx, alloc_idx;
    logic [OCC_W-1:0]   occ;
    logic               load_out, dispatch, do_issue, cdb_hit;

    always_comb begin
        ready     = '0;
        sel_any   = 1'b0;
        sel_idx   = '0;
        alloc_any = 1'b0;
        alloc_idx = '0;
        occ       = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
            occ      = occ + OCC_W'(busy_q[i]);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (!sel_any && ready[i] && ((ready & older_q[i]) == '0)) begin
                sel_any = 1'b1;
                sel_idx = IDX_W'(i);
            end
            if (!alloc_any && !busy_q[i]) begin
                alloc_any = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign load_out  = !ex_valid_q || ex_ready;
    assign dispatch  = load_out && sel_any;
    assign do_issue  = iss_valid && alloc_any;
    assign cdb_hit   = cdb_valid && (cdb_tag != '0);
    assign freed     = dispatch ? (ONE_HOT0 << sel_idx) : '0;

    assign iss_ready = alloc_any;
    assign iss_tag   = alloc_any ? (TAG_W'(RS_BASE) + TAG_W'(alloc_idx)) : '0;
    assign occupancy = occ;

    always_comb begin
        busy_d     = busy_q;
        op_d       = op_q;
        vj_d       = vj_q;
        vk_d       = vk_q;
        qj_d       = qj_q;
        qk_d       = qk_q;
        older_d    = older_q;
        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_vj_d    = ex_vj_q;
        ex_vk_d    = ex_vk_q;
        ex_tag_d   = ex_tag_q;

        for (int i = 0; i < ENTRIES; i++) begin
            if (busy_q[i] && cdb_hit) begin
                if (qj_q[i] == cdb_tag) begin
                    vj_d[i] = cdb_data;
                    qj_d[i] = '0;
                end
                if (qk_q[i] == cdb_tag) begin
                    vk_d[i] = cdb_data;
                    qk_d[i] = '0;
                end
            end
        end

        if (load_out) begin
            ex_valid_d = sel_any;
            if (sel_any) begin
                ex_op_d         = op_q[sel_idx];
                ex_vj_d         = vj_q[sel_idx];
                ex_vk_d         = vk_q[sel_idx];
                ex_tag_d        = TAG_W'(RS_BASE) + TAG_W'(sel_idx);
                busy_d[sel_idx] = 1'b0;
            end
        end
        for (int r = 0; r < ENTRIES; r++) begin
            older_d[r] = older_d[r] & ~freed;
        end

        // A broadcast in the issue cycle is captured here, since the entry is not yet snooping
        if (do_issue) begin
            busy_d[alloc_idx] = 1'b1;
            op_d[alloc_idx]   = iss_op;
            if (cdb_hit && (iss_qj == cdb_tag)) begin
                vj_d[alloc_idx] = cdb_data;
                qj_d[alloc_idx] = '0;
            end else begin
                vj_d[alloc_idx] = iss_vj;
                qj_d[alloc_idx] = iss_qj;
            end
            if (cdb_hit && (iss_qk == cdb_tag)) begin
                vk_d[alloc_idx] = cdb_data;
                qk_d[alloc_idx] = '0;
            end else begin
                vk_d[alloc_idx] = iss_vk;
                qk_d[alloc_idx] = iss_qk;
            end
            older_d[alloc_idx] = busy_q & ~freed;
        end

        if (flush) begin
            busy_d     = '0;
            older_d    = '{default: '0};
            ex_valid_d = 1'b0;
            ex_op_d    = '0;
            ex_vj_d    = '0;
            ex_vk_d    = '0;
            ex_tag_d   = '0;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            op_q       <= '{default: '0};
            vj_q       <= '{default: '0};
            vk_q       <= '{default: '0};
            qj_q       <= '{default: '0};
            qk_q       <= '{default: '0};
            older_q    <= '{default: '0};
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_vj_q    <= '0;
            ex_vk_q    <= '0;
            ex_tag_q   <= '0;
        end else begin
            busy_q     <= busy_d;
            op_q       <= op_d;
            vj_q       <= vj_d;
            vk_q       <= vk_d;
            qj_q       <= qj_d;
            qk_q       <= qk_d;
            older_q    <= older_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_vj_q    <= ex_vj_d;
            ex_vk_q    <= ex_vk_d;
            ex_tag_q   <= ex_tag_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_op    = ex_op_q;
    assign ex_vj    = ex_vj_q;
    assign ex_vk    = ex_vk_q;
    assign ex_tag   = ex_tag_q;
endmodule

// File: tb/tb_tomasulo_rs.sv
// tb/tb_tomasulo_rs.sv - Vector table and corner sequences with a dispatch scoreboard for tomasulo_rs
module tb_tomasulo_rs;
    localparam int ENTRIES = 4;
    localparam int DATA_W  = 16;
    localparam int TAG_W   = 3;
    localparam int OP_W    = 2;
    localparam int RS_BASE = 1;
    localparam int OCC_W   = $clog2(ENTRIES+1);

    logic              clk1 = 1'b0;
    logic              rst_n, flush, iss_valid, iss_ready, cdb_valid, ex_valid, ex_ready;
    logic [OP_W-1:0]   iss_op, ex_op;
    logic [DATA_W-1:0] iss_vj, iss_vk, cdb_data, ex_vj, ex_vk;
    logic [TAG_W-1:0]  iss_qj, iss_qk, iss_tag, cdb_tag, ex_tag;
    logic [OCC_W-1:0]  occupancy;

    tomasulo_rs #(.ENTRIES(ENTRIES), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .RS_BASE(RS_BASE)) dut (
        .clk1(clk1), .rst_n(rst_n), .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_qj(iss_qj), .iss_qk(iss_qk), .iss_tag(iss_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_tag(ex_tag), .occupancy(occupancy)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  tag;
    } exp_t;

    exp_t sb[$];
    exp_t vecs[6];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic push_exp(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] vj,
                            input logic [DATA_W-1:0] vk, input logic [TAG_W-1:0] tag);
        exp_t e;
        e.op  = op;
        e.vj  = vj;
        e.vk  = vk;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drive_issue(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] vj,
                               input logic [DATA_W-1:0] vk, input logic [TAG_W-1:0] qj,
                               input logic [TAG_W-1:0] qk);
        iss_valid = 1'b1;
        iss_op    = op;
        iss_vj    = vj;
        iss_vk    = vk;
        iss_qj    = qj;
        iss_qk    = qk;
    endtask

    task automatic drive_cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        tick();
    endtask

    always @(negedge clk1) begin : monitor
        exp_t e;
        if (rst_n && ex_valid && ex_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_dispatch: got tag %0d, want none", ex_tag);
            end else begin
                e = sb.pop_front();
                chk("disp_op", 32'(ex_op), 32'(e.op));
                chk("disp_vj", 32'(ex_vj), 32'(e.vj));
                chk("disp_vk", 32'(ex_vk), 32'(e.vk));
                chk("disp_tag", 32'(ex_tag), 32'(e.tag));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'd0, 16'h0001, 16'h1000, 3'd1};
        vecs[1] = '{2'd1, 16'h0002, 16'h2000, 3'd2};
        vecs[2] = '{2'd2, 16'hFFFF, 16'h0000, 3'd1};
        vecs[3] = '{2'd3, 16'h8000, 16'h7FFF, 3'd2};
        vecs[4] = '{2'd1, 16'h0000, 16'hFFFF, 3'd1};
        vecs[5] = '{2'd2, 16'h5A5A, 16'hA5A5, 3'd2};

        rst_n = 1'b0; flush = 1'b0; iss_valid = 1'b0; iss_op = '0; iss_vj = '0; iss_vk = '0;
        iss_qj = '0; iss_qk = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; ex_ready = 1'b1;
        repeat (2) @(posedge clk1);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_op", 32'(ex_op), 32'd0);
        chk("rst_ex_vj", 32'(ex_vj), 32'd0);
        chk("rst_ex_vk", 32'(ex_vk), 32'd0);
        chk("rst_ex_tag", 32'(ex_tag), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_iss_ready", 32'(iss_ready), 32'd1);
        chk("rst_iss_tag", 32'(iss_tag), 32'd1);

        // single issue, both operands present
        tick();
        drive_issue(2'd1, 16'd5, 16'd7, 3'd0, 3'd0); #1;
        chk("t1_iss_tag", 32'(iss_tag), 32'd1);
        push_exp(2'd1, 16'd5, 16'd7, 3'd1);
        tick(); iss_valid = 1'b0;
        chk("t1_occ_after_issue", 32'(occupancy), 32'd1);
        chk("t1_ex_valid_early", 32'(ex_valid), 32'd0);
        tick();
        chk("t1_ex_valid", 32'(ex_valid), 32'd1);
        chk("t1_ex_vj", 32'(ex_vj), 32'd5);
        chk("t1_ex_vk", 32'(ex_vk), 32'd7);
        chk("t1_ex_tag", 32'(ex_tag), 32'd1);
        chk("t1_occ_after_dispatch", 32'(occupancy), 32'd0);
        tick();

        // back-to-back table: freed entry is not reusable on its freeing edge, so tags alternate
        for (int i = 0; i < 6; i++) begin
            drive_issue(vecs[i].op, vecs[i].vj, vecs[i].vk, 3'd0, 3'd0); #1;
            chk("tbl_iss_tag", 32'(iss_tag), 32'(vecs[i].tag));
            push_exp(vecs[i].op, vecs[i].vj, vecs[i].vk, vecs[i].tag);
            tick();
        end
        iss_valid = 1'b0;
        drain(10);

        // wakeup of j two cycles after issue
        drive_issue(2'd2, 16'hBEEF, 16'h0011, 3'd3, 3'd0); #1;
        chk("wake_iss_tag", 32'(iss_tag), 32'd1);
        push_exp(2'd2, 16'h00AA, 16'h0011, 3'd1);
        tick(); iss_valid = 1'b0;
        tick();
        chk("wake_waiting", 32'(ex_valid), 32'd0);
        drive_cdb(3'd3, 16'h00AA);
        tick(); cdb_valid = 1'b0;
        chk("wake_not_yet", 32'(ex_valid), 32'd0);
        tick();
        chk("wake_ex_valid", 32'(ex_valid), 32'd1);
        chk("wake_ex_vj", 32'(ex_vj), 32'h00AA);
        tick();

        // cdb tag 0 must not touch a present operand; k wakes on tag 5
        drive_issue(2'd3, 16'h1234, 16'hFFFF, 3'd0, 3'd5); #1;
        push_exp(2'd3, 16'h1234, 16'h0055, 3'd1);
        tick(); iss_valid = 1'b0;
        drive_cdb(3'd0, 16'hDEAD);
        tick();
        drive_cdb(3'd5, 16'h0055);
        tick(); cdb_valid = 1'b0;
        tick();
        chk("tag0_ex_valid", 32'(ex_valid), 32'd1);
        chk("tag0_ex_vj", 32'(ex_vj), 32'h1234);
        tick();

        // issue-cycle bypass on j, then on k
        drive_issue(2'd0, 16'hAAAA, 16'h0004, 3'd3, 3'd0);
        drive_cdb(3'd3, 16'h0009); #1;
        push_exp(2'd0, 16'h0009, 16'h0004, 3'd1);
        tick(); iss_valid = 1'b0; cdb_valid = 1'b0;
        chk("bypj_not_yet", 32'(ex_valid), 32'd0);
        tick();
        chk("bypj_ex_valid", 32'(ex_valid), 32'd1);
        chk("bypj_ex_vj", 32'(ex_vj), 32'h0009);
        tick();
        drive_issue(2'd1, 16'h0002, 16'hBBBB, 3'd0, 3'd6);
        drive_cdb(3'd6, 16'h0066); #1;
        push_exp(2'd1, 16'h0002, 16'h0066, 3'd1);
        tick(); iss_valid = 1'b0; cdb_valid = 1'b0;
        tick();
        chk("bypk_ex_valid", 32'(ex_valid), 32'd1);
        chk("bypk_ex_vk", 32'(ex_vk), 32'h0066);
        tick();

        // fill all entries waiting on tag 7, then release in age order
        for (int i = 0; i < 4; i++) begin
            drive_issue(OP_W'(i), DATA_W'(32'hC000 + i), DATA_W'(32'h0100 + i), 3'd7, 3'd0); #1;
            chk("fill_iss_tag", 32'(iss_tag), 32'(i + 1));
            push_exp(OP_W'(i), 16'h0077, DATA_W'(32'h0100 + i), TAG_W'(i + 1));
            tick();
        end
        drive_issue(2'd3, 16'hEEEE, 16'hEEEE, 3'd0, 3'd0); #1;
        chk("full_iss_ready", 32'(iss_ready), 32'd0);
        chk("full_iss_tag", 32'(iss_tag), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd4);
        tick(); iss_valid = 1'b0;
        chk("full_occ_held", 32'(occupancy), 32'd4);
        drive_cdb(3'd7, 16'h0077);
        tick(); cdb_valid = 1'b0;
        chk("full_still_not_ready", 32'(iss_ready), 32'd0);
        chk("full_ex_valid_early", 32'(ex_valid), 32'd0);
        tick();
        chk("full_first_tag", 32'(ex_tag), 32'd1);
        chk("full_occ_3", 32'(occupancy), 32'd3);
        chk("full_iss_ready_rise", 32'(iss_ready), 32'd1);
        drain(10);

        // stall output while an older entry in a higher slot wakes
        ex_ready = 1'b0;
        drive_issue(2'd2, 16'h0A0A, 16'h0B0B, 3'd0, 3'd0); #1;
        chk("age_a_tag", 32'(iss_tag), 32'd1);
        push_exp(2'd2, 16'h0A0A, 16'h0B0B, 3'd1);
        tick();
        drive_issue(2'd1, 16'h0000, 16'h0C0C, 3'd5, 3'd0); #1;
        chk("age_b_tag", 32'(iss_tag), 32'd2);
        push_exp(2'd1, 16'h0505, 16'h0C0C, 3'd2);
        tick();
        drive_issue(2'd3, 16'h0D0D, 16'h0E0E, 3'd0, 3'd0); #1;
        chk("age_c_tag", 32'(iss_tag), 32'd1);
        push_exp(2'd3, 16'h0D0D, 16'h0E0E, 3'd1);
        tick(); iss_valid = 1'b0;
        drive_cdb(3'd5, 16'h0505);
        tick(); cdb_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stall_ex_valid", 32'(ex_valid), 32'd1);
            chk("stall_ex_tag", 32'(ex_tag), 32'd1);
            chk("stall_ex_vj", 32'(ex_vj), 32'h0A0A);
            tick();
        end
        chk("stall_occ", 32'(occupancy), 32'd2);
        ex_ready = 1'b1;
        tick();
        chk("age_next_tag", 32'(ex_tag), 32'd2);
        drain(10);

        // flush with three busy entries and a held output
        ex_ready = 1'b0;
        drive_issue(2'd0, 16'h1111, 16'h1111, 3'd0, 3'd0); tick();
        drive_issue(2'd1, 16'h2222, 16'h2222, 3'd7, 3'd0); tick();
        drive_issue(2'd2, 16'h3333, 16'h3333, 3'd7, 3'd0); tick();
        drive_issue(2'd3, 16'h4444, 16'h4444, 3'd7, 3'd0); tick();
        iss_valid = 1'b0;
        chk("preflush_occ", 32'(occupancy), 32'd3);
        chk("preflush_ex_valid", 32'(ex_valid), 32'd1);
        flush = 1'b1;
        tick(); flush = 1'b0; #1;
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_ex_valid", 32'(ex_valid), 32'd0);
        chk("flush_iss_ready", 32'(iss_ready), 32'd1);
        chk("flush_iss_tag", 32'(iss_tag), 32'd1);
        ex_ready = 1'b1;
        drive_cdb(3'd7, 16'h0777);
        tick(); cdb_valid = 1'b0;
        tick();
        chk("flush_no_ghost", 32'(ex_valid), 32'd0);

        // asynchronous reset mid-cycle
        ex_ready = 1'b0;
        drive_issue(2'd1, 16'h3333, 16'h4444, 3'd0, 3'd0); tick();
        drive_issue(2'd2, 16'h5555, 16'h6666, 3'd7, 3'd0); tick();
        iss_valid = 1'b0;
        tick();
        chk("prerst_ex_valid", 32'(ex_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ex_valid", 32'(ex_valid), 32'd0);
        chk("arst_ex_op", 32'(ex_op), 32'd0);
        chk("arst_ex_vj", 32'(ex_vj), 32'd0);
        chk("arst_ex_tag", 32'(ex_tag), 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_iss_ready", 32'(iss_ready), 32'd1);
        chk("arst_iss_tag", 32'(iss_tag), 32'd1);
        tick(); rst_n = 1'b1; ex_ready = 1'b1;
        tick(); tick();
        chk("post_rst_idle", 32'(ex_valid), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
